alu_operand_stage: RTL and testbench

- Parametrised successor to the single-operand ALU mux.
- Selects both ALU operands (A: rs1/PC/zero; B: rs2/immediate) and resolves register operands through a priority forwarding network.
- Detects operands whose producer has not yet returned data and stalls on them.
- Registers the result into a valid-tagged decode→execute pipeline register with stall and flush support.
- Sits at the decode/execute boundary of the 3-stage core, feeding the ALU and the store-data path.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/alu_operand_stage_fwd_select.sv | 33 +++
 rtl/alu_operand_stage.sv | 119 +++++++++++
 tb/tb_alu_operand_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths and operand-A select encoding for the decode/execute boundary
package riscv_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'd0,
    OPA_PC   = 2'd1,
    OPA_ZERO = 2'd2
  } opa_sel_e;

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// rtl/alu_operand_stage_fwd_select.sv - priority forwarding matcher for one source register
module fwd_select #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
) (
  input  logic [REG_AW-1:0]         addr_i,
  input  logic [XLEN-1:0]           rdata_i,
  input  logic [NUM_FWD-1:0]        fwd_valid_i,
  input  logic [NUM_FWD-1:0]        fwd_busy_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
  output logic [XLEN-1:0]           value_o,
  output logic                      hit_o,
  output logic                      busy_o
);

  // Walk from oldest to youngest so the youngest (lowest index) match lands last.
  always_comb begin
    value_o = rdata_i;
    hit_o   = 1'b0;
    busy_o  = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && (addr_i != '0) &&
          (fwd_rd_i[i*REG_AW +: REG_AW] == addr_i)) begin
        value_o = fwd_data_i[i*XLEN +: XLEN];
        hit_o   = 1'b1;
        busy_o  = fwd_busy_i[i];
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand select, forwarding and decode->execute pipeline register
module alu_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = REG_AW_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic [REG_AW-1:0]         rs1_addr,
  input  logic [REG_AW-1:0]         rs2_addr,
  input  logic [XLEN-1:0]           rdata1,
  input  logic [XLEN-1:0]           rdata2,
  input  logic [XLEN-1:0]           pc,
  input  logic [XLEN-1:0]           sign_extended_imm,
  input  logic [1:0]                opa_sel,
  input  logic                      imm_en,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_busy,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      out_valid,
  output logic [XLEN-1:0]           opr_a,
  output logic [XLEN-1:0]           opr_b,
  output logic [XLEN-1:0]           store_data,
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b
);

  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_hit, rs2_hit, rs1_busy, rs2_busy;
  logic            use_rs1, hazard;

  fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) u_fwd_rs1 (
    .addr_i(rs1_addr), .rdata_i(rdata1),
    .fwd_valid_i(fwd_valid), .fwd_busy_i(fwd_busy),
    .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
    .value_o(rs1_val), .hit_o(rs1_hit), .busy_o(rs1_busy)
  );

  fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) u_fwd_rs2 (
    .addr_i(rs2_addr), .rdata_i(rdata2),
    .fwd_valid_i(fwd_valid), .fwd_busy_i(fwd_busy),
    .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
    .value_o(rs2_val), .hit_o(rs2_hit), .busy_o(rs2_busy)
  );

  // rs2 always matters: even with an immediate B it feeds store_data.
  assign use_rs1  = (opa_sel == OPA_RS1);
  assign hazard   = (use_rs1 && rs1_busy) || rs2_busy;
  assign in_ready = !rst && !stall_i && !hazard;

  logic [XLEN-1:0] opa_val;
  always_comb begin
    case (opa_sel)
      OPA_RS1: opa_val = rs1_val;
      OPA_PC:  opa_val = pc;
      default: opa_val = '0;
    endcase
  end

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] opr_a_d, opr_a_q, opr_b_d, opr_b_q, store_data_d, store_data_q;
  logic            hit_a_d, hit_a_q, hit_b_d, hit_b_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    opr_a_d      = opr_a_q;
    opr_b_d      = opr_b_q;
    store_data_d = store_data_q;
    hit_a_d      = hit_a_q;
    hit_b_d      = hit_b_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (stall_i) begin
      out_valid_d = out_valid_q;
    end else if (hazard && in_valid) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d  = in_valid;
      opr_a_d      = opa_val;
      opr_b_d      = imm_en ? sign_extended_imm : rs2_val;
      store_data_d = rs2_val;
      hit_a_d      = use_rs1 && rs1_hit;
      hit_b_d      = !imm_en && rs2_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      opr_a_q      <= '0;
      opr_b_q      <= '0;
      store_data_q <= '0;
      hit_a_q      <= 1'b0;
      hit_b_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      opr_a_q      <= opr_a_d;
      opr_b_q      <= opr_b_d;
      store_data_q <= store_data_d;
      hit_a_q      <= hit_a_d;
      hit_b_q      <= hit_b_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign opr_a      = opr_a_q;
  assign opr_b      = opr_b_q;
  assign store_data = store_data_q;
  assign fwd_hit_a  = hit_a_q;
  assign fwd_hit_b  = hit_b_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed and randomized checks of alu_operand_stage against a reference model
module tb_alu_operand_stage;

  localparam int XLEN = 32;
  localparam int NF   = 2;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst, in_valid, stall_i, flush_i, imm_en;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rdata1, rdata2, pc, imm;
  logic [1:0]      opa_sel;
  logic [NF-1:0]   fwd_valid, fwd_busy;
  logic [AW-1:0]   f_rd [NF];
  logic [XLEN-1:0] f_data [NF];
  logic [NF*AW-1:0]   fwd_rd;
  logic [NF*XLEN-1:0] fwd_data;

  logic            in_ready, out_valid, fwd_hit_a, fwd_hit_b;
  logic [XLEN-1:0] opr_a, opr_b, store_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic            e_valid, e_ha, e_hb, e_data_ok;
  logic [XLEN-1:0] e_a, e_b, e_sd;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NF; i++) begin
      fwd_rd[i*AW +: AW]     = f_rd[i];
      fwd_data[i*XLEN +: XLEN] = f_data[i];
    end
  end

  alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NF), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .stall_i(stall_i), .flush_i(flush_i),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rdata1(rdata1), .rdata2(rdata2),
    .pc(pc), .sign_extended_imm(imm), .opa_sel(opa_sel), .imm_en(imm_en),
    .fwd_valid(fwd_valid), .fwd_busy(fwd_busy), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .opr_a(opr_a), .opr_b(opr_b), .store_data(store_data),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Youngest valid source naming the register supplies it; x0 never forwards.
  task automatic resolve(input logic [AW-1:0] r, input logic [XLEN-1:0] rd,
                         output logic [XLEN-1:0] v, output logic hit, output logic busy);
    v = rd; hit = 1'b0; busy = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (!hit && fwd_valid[i] && r != 0 && f_rd[i] == r) begin
        v = f_data[i]; hit = 1'b1; busy = fwd_busy[i];
      end
    end
  endtask

  task automatic step(input string tag);
    logic [XLEN-1:0] v1, v2;
    logic h1, b1, h2, b2, haz;
    #1;
    resolve(rs1_addr, rdata1, v1, h1, b1);
    resolve(rs2_addr, rdata2, v2, h2, b2);
    haz = (opa_sel == 2'd0 && b1) || b2;
    chk({tag, ":in_ready"}, {31'b0, in_ready}, {31'b0, !rst && !stall_i && !haz});
    if (rst) begin
      e_valid = 0; e_a = 0; e_b = 0; e_sd = 0; e_ha = 0; e_hb = 0; e_data_ok = 1;
    end else if (flush_i) begin
      e_valid = 0; e_data_ok = 0;
    end else if (stall_i) begin
      e_valid = e_valid;
    end else if (haz && in_valid) begin
      e_valid = 0; e_data_ok = 0;
    end else begin
      e_valid = in_valid;
      e_a  = (opa_sel == 2'd0) ? v1 : (opa_sel == 2'd1) ? pc : '0;
      e_b  = imm_en ? imm : v2;
      e_sd = v2;
      e_ha = (opa_sel == 2'd0) && h1;
      e_hb = !imm_en && h2;
      e_data_ok = 1;
    end
    @(posedge clk);
    #1;
    chk({tag, ":out_valid"}, {31'b0, out_valid}, {31'b0, e_valid});
    if (e_data_ok) begin
      chk({tag, ":opr_a"}, opr_a, e_a);
      chk({tag, ":opr_b"}, opr_b, e_b);
      chk({tag, ":store_data"}, store_data, e_sd);
      chk({tag, ":fwd_hit_a"}, {31'b0, fwd_hit_a}, {31'b0, e_ha});
      chk({tag, ":fwd_hit_b"}, {31'b0, fwd_hit_b}, {31'b0, e_hb});
    end
  endtask

  task automatic rand_instr(input bit allow_busy);
    rs1_addr = AW'($urandom_range(0, 7));
    rs2_addr = AW'($urandom_range(0, 7));
    rdata1 = $urandom; rdata2 = $urandom; pc = $urandom; imm = $urandom;
    opa_sel = 2'($urandom_range(0, 3));
    imm_en = 1'($urandom);
    fwd_valid = NF'($urandom);
    fwd_busy  = allow_busy ? NF'($urandom) : '0;
    for (int i = 0; i < NF; i++) begin
      f_rd[i] = AW'($urandom_range(0, 7));
      f_data[i] = $urandom;
    end
  endtask

  task automatic no_fwd();
    fwd_valid = '0; fwd_busy = '0;
    for (int i = 0; i < NF; i++) begin
      f_rd[i] = '0; f_data[i] = '0;
    end
  endtask

  initial begin
    e_valid = 0; e_a = 0; e_b = 0; e_sd = 0; e_ha = 0; e_hb = 0; e_data_ok = 0;
    rst = 1; stall_i = 0; flush_i = 0; in_valid = 1;
    rand_instr(1);
    step("reset0");
    rand_instr(1); stall_i = 1'($urandom);
    step("reset1");

    rst = 0; stall_i = 0; flush_i = 0; in_valid = 0; no_fwd();
    #1;
    chk("release:in_ready", {31'b0, in_ready}, 32'd1);

    in_valid = 1; opa_sel = 2'd2; rs1_addr = 1; rs2_addr = 2;
    rdata2 = 32'h0000_0005; imm = 32'hFFFF_FFF0; imm_en = 1;
    step("imm");
    chk("imm:opr_b_const", opr_b, 32'hFFFF_FFF0);
    chk("imm:store_const", store_data, 32'h5);
    imm_en = 0;
    step("reg");
    chk("reg:opr_b_const", opr_b, 32'h5);
    chk("reg:store_const", store_data, 32'h5);

    opa_sel = 2'd0; rs1_addr = 7; rdata1 = 32'h0BAD_0BAD; fwd_valid = 2'b11;
    f_rd[0] = 7; f_data[0] = 32'hAAAA_0000; f_rd[1] = 7; f_data[1] = 32'hBBBB_0000;
    step("prio");
    chk("prio:opr_a_const", opr_a, 32'hAAAA_0000);
    chk("prio:hit_a_const", {31'b0, fwd_hit_a}, 32'd1);
    rs1_addr = 0; f_rd[0] = 0; f_rd[1] = 0; rdata1 = 32'h0000_0042;
    step("x0");
    chk("x0:opr_a_const", opr_a, 32'h42);
    chk("x0:hit_a_const", {31'b0, fwd_hit_a}, 32'd0);

    no_fwd(); opa_sel = 2'd2; rs1_addr = 1; rs2_addr = 3;
    fwd_valid = 2'b01; f_rd[0] = 3; fwd_busy = 2'b01; f_data[0] = 32'hDEAD_BEEF;
    step("lu0");
    step("lu1");
    fwd_busy = 2'b00; f_data[0] = 32'h0000_1234;
    step("lu2");
    chk("lu2:store_const", store_data, 32'h1234);
    chk("lu2:valid_const", {31'b0, out_valid}, 32'd1);
    opa_sel = 2'd1; rs1_addr = 5; rs2_addr = 6; f_rd[0] = 5; fwd_busy = 2'b01;
    step("pc_busy_rs1");

    no_fwd(); opa_sel = 2'd1; pc = 32'h10;
    step("cap");
    chk("cap:opr_a_const", opr_a, 32'h10);
    stall_i = 1; pc = 32'h20;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall:opr_a_const", opr_a, 32'h10);
    end
    flush_i = 1;
    step("flush");
    chk("flush:valid_const", {31'b0, out_valid}, 32'd0);
    flush_i = 0; stall_i = 0;

    for (int i = 0; i < 8; i++) begin
      rand_instr(0); in_valid = 1;
      step("b2b");
    end

    stall_i = 1; rand_instr(1); fwd_busy = '1; rst = 1;
    step("rst_stall");
    rst = 0; stall_i = 0; in_valid = 0;
    step("rst_after");

    for (int i = 0; i < 300; i++) begin
      rand_instr(1);
      in_valid = 1'($urandom);
      stall_i  = ($urandom_range(0, 3) == 0);
      flush_i  = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
